// File: rtl/adc_scheduler.sv
// ---------------------------------------------------------------------------
// adc_scheduler
//
// Round-robin scheduler sharing one XADC conversion wrapper between up to
// NREQ on-chip requesters. Each grant issues a single start pulse, waits
// for the wrapper's conv_done, then returns the 16-bit result with a
// one-cycle acknowledge to the granted requester. Only one conversion is
// outstanding at any time.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   GUARD   - cycles after adc_start during which conv_done is ignored (1..15)
//   TIMEOUT - WAIT-state cycle limit, used only with the watchdog (4..65536)
//
// Ports:
//   clk       in   system clock, shared with the wrapper
//   reset     in   asynchronous, active-high reset
//   req       in   level request per requester, held until its ack
//   ack       out  one-cycle one-hot pulse; sample/err valid in that cycle
//   sample    out  conversion result, held until the next ack
//   err       out  set with ack when the conversion timed out
//   busy      out  high in every state except IDLE
//   owner     out  index of the current or last granted requester
//   adc_start out  one-cycle start pulse to the wrapper
//   adc_data  in   wrapper output {do[15:0], conv_done}
//
// Build option:
//   ADC_SCHED_TIMEOUT_EN - when defined, a 16-bit watchdog aborts a WAIT
//   that lasts TIMEOUT cycles and returns err=1 with sample=0. When left
//   undefined, WAIT lasts until conv_done and err is tied low.
// ---------------------------------------------------------------------------
module adc_scheduler #(
    parameter int NREQ    = 4,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         ack,
    output logic [15:0]             sample,
    output logic                    err,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] owner,
    output logic                    adc_start,
    input  logic [16:0]             adc_data
);

    localparam int IDX_W = $clog2(NREQ);

    // Elaboration-time range checks on the configuration.
    generate
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("adc_scheduler: NREQ must be in 2..8");
        end
        if (GUARD < 1 || GUARD > 15) begin : g_bad_guard
            $error("adc_scheduler: GUARD must be in 1..15");
        end
        if (TIMEOUT < 4 || TIMEOUT > 65536) begin : g_bad_timeout
            $error("adc_scheduler: TIMEOUT must be in 4..65536");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_GUARD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q,  last_d;
    logic [3:0]       guard_cnt_q, guard_cnt_d;
    logic [15:0]      sample_q, sample_d;

    logic             conv_done;
    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] cand;

`ifdef ADC_SCHED_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
`endif

    assign conv_done = adc_data[0];

    // Increment modulo NREQ; NREQ need not be a power of two.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NREQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Round-robin arbiter: search starts just after the last served index,
    // so a requester that keeps req high is reconsidered only after every
    // other index has been looked at.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = next_idx(last_q);
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
            cand = next_idx(cand);
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and datapath update.
    // -----------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        guard_cnt_d = guard_cnt_q;
        sample_d    = sample_q;
`ifdef ADC_SCHED_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    owner_d = grant_idx;
                    state_d = S_START;
                end
            end

            S_START: begin
                guard_cnt_d = '0;
                state_d     = S_GUARD;
            end

            // The wrapper clears its stale conv_done during these cycles,
            // so adc_data is deliberately not looked at here.
            S_GUARD: begin
                if (guard_cnt_q == 4'(GUARD - 1)) begin
                    state_d = S_WAIT;
`ifdef ADC_SCHED_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end else begin
                    guard_cnt_d = guard_cnt_q + 4'd1;
                end
            end

            // conv_done is tested first so it wins over a coinciding timeout.
            S_WAIT: begin
                if (conv_done) begin
                    sample_d = adc_data[16:1];
                    state_d  = S_DONE;
`ifdef ADC_SCHED_TIMEOUT_EN
                    err_d    = 1'b0;
`endif
                end
`ifdef ADC_SCHED_TIMEOUT_EN
                else if (wait_cnt_q == WAIT_LAST) begin
                    sample_d = '0;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end

            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register.
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers.
    // -----------------------------------------------------------------------
    // NOTE: sample and the pointers are plain control registers, not memory,
    // so all of them take a defined reset value; last starts at NREQ-1 so
    // requester 0 wins the first arbitration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= '0;
            last_q      <= IDX_W'(NREQ - 1);
            guard_cnt_q <= '0;
            sample_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            last_q      <= last_d;
            guard_cnt_q <= guard_cnt_d;
            sample_q    <= sample_d;
        end
    end

`ifdef ADC_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs: registers or decodes of the state register only, so neither
    // req nor adc_data has a combinational path to any output, and the
    // asynchronous reset clears busy/adc_start/ack immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        ack = '0;
        if (state_q == S_DONE) begin
            ack[owner_q] = 1'b1;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign adc_start = (state_q == S_START);
    assign owner     = owner_q;
    assign sample    = sample_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for adc_scheduler (NREQ=4, GUARD=2, TIMEOUT=16).
// A cycle-stepping wrapper model answers each adc_start after a chosen
// latency. Expected grants come from a plain round-robin search over the
// request vector, and expected timing from the cycle rules of the block.
// ---------------------------------------------------------------------------
module tb_adc_scheduler;

    localparam int NREQ    = 4;
    localparam int GUARD   = 2;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [15:0] sample;
    logic        err;
    logic        busy;
    logic [1:0]  owner;
    logic        adc_start;
    logic [16:0] adc_data;

    adc_scheduler #(.NREQ(NREQ), .GUARD(GUARD), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .sample    (sample),
        .err       (err),
        .busy      (busy),
        .owner     (owner),
        .adc_start (adc_start),
        .adc_data  (adc_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Observed events, recorded by tick().
    int          n_ack = 0, n_start = 0, bad_ack = 0;
    int          last_ack_cyc = -1, last_start_cyc = -1;
    logic [3:0]  last_ack;
    logic [15:0] last_sample;
    logic        last_err;
    logic [1:0]  last_owner;

    // Wrapper model: conv_done rises wrap_lat cycles after the start cycle
    // (never when wrap_lat is 0) and stays high until the next start.
    bit          wrap_auto = 1'b1;
    int          wrap_lat  = 0;
    int          wrap_cnt  = 0;
    logic [15:0] wrap_data = '0;

    // Round-robin reference: first requester after 'last', wrapping.
    function automatic int rr_pick(input int last, input logic [3:0] r);
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = (last + off) % NREQ;
            if (r[2'(idx)]) return idx;
        end
        return -1;
    endfunction

    // Advance one clock; afterwards outputs are settled for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (adc_start === 1'b1) begin
            n_start++;
            last_start_cyc = cyc;
        end
        if (ack !== 4'b0000) begin
            n_ack++;
            last_ack_cyc = cyc;
            last_ack     = ack;
            last_sample  = sample;
            last_err     = err;
            last_owner   = owner;
            if ($countones(ack) != 1 || busy !== 1'b1) bad_ack++;
        end
        if (wrap_auto) begin
            if (adc_start === 1'b1) begin
                wrap_cnt = wrap_lat;
                adc_data = {16'($urandom), 1'b0};
            end else if (wrap_cnt > 0) begin
                wrap_cnt--;
                if (wrap_cnt == 0) adc_data = {wrap_data, 1'b1};
            end
        end
    endtask

    task automatic wait_ack(input int budget, input string name);
        int n0;
        n0 = n_ack;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (n_ack != n0) return;
        end
        errors++;
        checks++;
        $display("FAIL %s_wait: no ack within %0d cycles", name, budget);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        req      = '0;
        adc_data = '0;
        wrap_cnt = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset    = 1'b1;
        req      = '0;
        adc_data = '0;
        repeat (3) tick();
        checks++; if (ack !== 4'b0)        begin errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        checks++; if (sample !== 16'h0)    begin errors++; $display("FAIL reset_sample: got %h want 0000", sample); end
        checks++; if (err !== 1'b0)        begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (adc_start !== 1'b0)  begin errors++; $display("FAIL reset_start: got %b want 0", adc_start); end
        checks++; if (owner !== 2'd0)      begin errors++; $display("FAIL reset_owner: got %0d want 0", owner); end
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_single();
        int c0, s0, a0;
        wrap_auto = 1'b1;
        wrap_lat  = 7;
        wrap_data = 16'hA5C0;
        c0 = cyc; s0 = n_start; a0 = n_ack;
        req = 4'b0001;
        tick();
        checks++; if (adc_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1 at cycle 1", adc_start); end
        tick();
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL single_start_len: got %b want 0 at cycle 2", adc_start); end
        wait_ack(30, "single");
        req = '0;
        checks++; if (last_ack_cyc != c0 + 9)  begin errors++; $display("FAIL single_ack_cyc: got %0d want %0d", last_ack_cyc - c0, 9); end
        checks++; if (last_ack !== 4'b0001)    begin errors++; $display("FAIL single_ack: got %b want 0001", last_ack); end
        checks++; if (last_sample !== 16'hA5C0) begin errors++; $display("FAIL single_sample: got %h want a5c0", last_sample); end
        checks++; if (last_owner !== 2'd0)     begin errors++; $display("FAIL single_owner: got %0d want 0", last_owner); end
        checks++; if (last_err !== 1'b0)       begin errors++; $display("FAIL single_err: got %b want 0", last_err); end
        repeat (3) tick();
        checks++; if (n_start - s0 != 1) begin errors++; $display("FAIL single_nstart: got %0d want 1", n_start - s0); end
        checks++; if (n_ack - a0 != 1)   begin errors++; $display("FAIL single_nack: got %0d want 1", n_ack - a0); end
        checks++; if (sample !== 16'hA5C0) begin errors++; $display("FAIL single_hold: got %h want a5c0", sample); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_stale_done();
        int c0, a0;
        wrap_auto = 1'b0;
        c0 = cyc; a0 = n_ack;
        adc_data = {16'h1111, 1'b1};
        req = 4'b0001;
        repeat (GUARD + 2) tick();           // first WAIT cycle
        checks++; if (n_ack != a0) begin errors++; $display("FAIL stale_guard: got %0d acks want 0 (sample %h)", n_ack - a0, last_sample); end
        adc_data = {16'h2222, 1'b0};
        repeat (3) tick();
        checks++; if (n_ack != a0) begin errors++; $display("FAIL stale_low: got %0d acks want 0", n_ack - a0); end
        adc_data = {16'h7E3D, 1'b1};
        wait_ack(10, "stale");
        req = '0;
        checks++; if (last_ack_cyc != c0 + GUARD + 6) begin errors++; $display("FAIL stale_ack_cyc: got %0d want %0d", last_ack_cyc - c0, GUARD + 6); end
        checks++; if (last_sample !== 16'h7E3D) begin errors++; $display("FAIL stale_sample: got %h want 7e3d", last_sample); end
        checks++; if (last_ack !== 4'b0001)     begin errors++; $display("FAIL stale_ack: got %b want 0001", last_ack); end
        tick();
        wrap_auto = 1'b1;
        wrap_cnt  = 0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_fairness();
        int          exp_order[6] = '{0, 1, 2, 3, 0, 1};
        int          c0, s0, a0, prev_ack, exp_k;
        logic [3:0]  exp_vec;
        do_reset();
        c0 = cyc; s0 = n_start; a0 = n_ack; prev_ack = -1;
        req = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            wrap_lat  = $urandom_range(1, 9);
            wrap_data = 16'($urandom);
            wait_ack(40, "fair");
            if (k == 5) req = '0;
            exp_vec = 4'b0001 << exp_order[k];
            exp_k   = (wrap_lat > GUARD + 1) ? last_start_cyc + wrap_lat : last_start_cyc + GUARD + 1;
            checks++; if (last_owner !== 2'(exp_order[k])) begin errors++; $display("FAIL fair_owner[%0d]: got %0d want %0d", k, last_owner, exp_order[k]); end
            checks++; if (last_ack !== exp_vec)            begin errors++; $display("FAIL fair_ack[%0d]: got %b want %b", k, last_ack, exp_vec); end
            checks++; if (last_sample !== wrap_data)       begin errors++; $display("FAIL fair_sample[%0d]: got %h want %h", k, last_sample, wrap_data); end
            checks++; if (last_ack_cyc != exp_k + 1)       begin errors++; $display("FAIL fair_ack_cyc[%0d]: got %0d want %0d", k, last_ack_cyc, exp_k + 1); end
            checks++;
            if (last_start_cyc != ((k == 0) ? c0 + 1 : prev_ack + 2)) begin
                errors++; $display("FAIL fair_start_cyc[%0d]: got %0d want %0d", k, last_start_cyc, (k == 0) ? c0 + 1 : prev_ack + 2);
            end
            prev_ack = last_ack_cyc;
            tick();
            checks++; if (ack !== 4'b0) begin errors++; $display("FAIL fair_pulse[%0d]: got %b want 0000", k, ack); end
        end
        checks++; if (n_start - s0 != 6) begin errors++; $display("FAIL fair_nstart: got %0d want 6", n_start - s0); end
        checks++; if (n_ack - a0 != 6)   begin errors++; $display("FAIL fair_nack: got %0d want 6", n_ack - a0); end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_drop();
        int exp_o;
        exp_o     = rr_pick(1, 4'b0101);     // last grant was 1
        wrap_lat  = 12;
        wrap_data = 16'($urandom);
        req = 4'b0101;
        repeat (GUARD + 3) tick();           // inside WAIT
        req = 4'b0011;                       // requester 2 drops
        wait_ack(30, "drop");
        checks++; if (last_ack !== 4'b0100)   begin errors++; $display("FAIL drop_ack: got %b want 0100", last_ack); end
        checks++; if (last_owner !== 2'(exp_o)) begin errors++; $display("FAIL drop_owner: got %0d want %0d", last_owner, exp_o); end
        checks++; if (last_sample !== wrap_data) begin errors++; $display("FAIL drop_sample: got %h want %h", last_sample, wrap_data); end
        exp_o     = rr_pick(2, 4'b0011);
        wrap_lat  = 4;
        wrap_data = 16'($urandom);
        wait_ack(30, "drop_next");
        req = '0;
        checks++; if (last_owner !== 2'(exp_o)) begin errors++; $display("FAIL drop_next_owner: got %0d want %0d", last_owner, exp_o); end
        checks++; if (last_ack !== 4'b0001)     begin errors++; $display("FAIL drop_next_ack: got %b want 0001", last_ack); end
        tick();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid();
        int c0, a0;
        wrap_lat = 0;                        // wrapper never completes
        a0 = n_ack;
        req = 4'b1000;
        repeat (GUARD + 4) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_pre: got %b want 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (adc_start !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b want 0", adc_start); end
        checks++; if (ack !== 4'b0)       begin errors++; $display("FAIL rmid_ack: got %b want 0000", ack); end
        tick();
        tick();
        checks++; if (n_ack != a0) begin errors++; $display("FAIL rmid_noack: got %0d acks want 0", n_ack - a0); end
        reset = 1'b0;
        c0 = cyc;
        req = 4'b0010;
        wrap_lat  = 5;
        wrap_data = 16'($urandom);
        wait_ack(30, "rmid");
        req = '0;
        checks++; if (last_owner !== 2'd1)     begin errors++; $display("FAIL rmid_owner: got %0d want 1", last_owner); end
        checks++; if (last_ack !== 4'b0010)    begin errors++; $display("FAIL rmid_grant: got %b want 0010", last_ack); end
        checks++; if (last_start_cyc != c0 + 1) begin errors++; $display("FAIL rmid_start_cyc: got %0d want %0d", last_start_cyc - c0, 1); end
        tick();
    endtask

`ifdef ADC_SCHED_TIMEOUT_EN
    // -----------------------------------------------------------------------
    task automatic test_timeout();
        int c0;
        wrap_lat = 0;
        c0 = cyc;
        req = 4'b0001;
        wait_ack(60, "tmo");
        req = '0;
        checks++; if (last_ack_cyc != c0 + GUARD + 2 + TIMEOUT) begin errors++; $display("FAIL tmo_cyc: got %0d want %0d", last_ack_cyc - c0, GUARD + 2 + TIMEOUT); end
        checks++; if (last_err !== 1'b1)    begin errors++; $display("FAIL tmo_err: got %b want 1", last_err); end
        checks++; if (last_sample !== 16'h0) begin errors++; $display("FAIL tmo_sample: got %h want 0000", last_sample); end
        tick();
        // conv_done arrives on the same WAIT cycle the limit is reached.
        wrap_lat  = GUARD + TIMEOUT;
        wrap_data = 16'($urandom) | 16'h0001;
        c0 = cyc;
        req = 4'b0001;
        wait_ack(60, "tmo_tie");
        req = '0;
        checks++; if (last_ack_cyc != c0 + GUARD + 2 + TIMEOUT) begin errors++; $display("FAIL tie_cyc: got %0d want %0d", last_ack_cyc - c0, GUARD + 2 + TIMEOUT); end
        checks++; if (last_err !== 1'b0)       begin errors++; $display("FAIL tie_err: got %b want 0", last_err); end
        checks++; if (last_sample !== wrap_data) begin errors++; $display("FAIL tie_sample: got %h want %h", last_sample, wrap_data); end
        tick();
    endtask
`endif

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        int         model_last, exp_o, exp_s, lat, exp_k, s0, a0;
        logic [3:0] exp_vec;
        do_reset();
        s0 = n_start; a0 = n_ack;
        model_last = NREQ - 1;
        req   = 4'($urandom_range(1, 15));
        exp_o = rr_pick(model_last, req);
        exp_s = cyc + 1;
        for (int it = 0; it < 40; it++) begin
            lat       = $urandom_range(1, 10);
            wrap_lat  = lat;
            wrap_data = 16'($urandom);
            while (cyc < exp_s) tick();
            req = req | 4'($urandom);        // late arrivals during START
            wait_ack(40, "b2b");
            exp_vec = 4'b0001 << exp_o;
            exp_k   = (lat > GUARD + 1) ? exp_s + lat : exp_s + GUARD + 1;
            checks++; if (last_start_cyc != exp_s)  begin errors++; $display("FAIL b2b_start[%0d]: got %0d want %0d", it, last_start_cyc, exp_s); end
            checks++; if (last_ack_cyc != exp_k + 1) begin errors++; $display("FAIL b2b_ack_cyc[%0d]: got %0d want %0d", it, last_ack_cyc, exp_k + 1); end
            checks++; if (last_ack !== exp_vec)      begin errors++; $display("FAIL b2b_ack[%0d]: got %b want %b", it, last_ack, exp_vec); end
            checks++; if (last_sample !== wrap_data) begin errors++; $display("FAIL b2b_sample[%0d]: got %h want %h", it, last_sample, wrap_data); end
            checks++; if (last_err !== 1'b0)         begin errors++; $display("FAIL b2b_err[%0d]: got %b want 0", it, last_err); end
            model_last = exp_o;
            if ($urandom_range(0, 1) == 1) req[2'(exp_o)] = 1'b0;
            if (req == 4'b0) req = 4'b0001 << $urandom_range(0, 3);
            exp_o = rr_pick(model_last, req);
            exp_s = cyc + 2;
        end
        req = '0;
        repeat (2) tick();
        checks++; if (n_start - s0 != n_ack - a0) begin errors++; $display("FAIL b2b_counts: starts %0d acks %0d", n_start - s0, n_ack - a0); end
        checks++; if (bad_ack != 0) begin errors++; $display("FAIL ack_onehot: got %0d bad pulses want 0", bad_ack); end
    endtask

    initial begin
        req      = '0;
        adc_data = '0;
        reset    = 1'b1;
        test_reset();
        test_single();
        test_stale_done();
        test_fairness();
        test_drop();
        test_reset_mid();
`ifdef ADC_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
